llc_event_scheduler: RTL and testbench

Sequences the RTLola monitor's low-level controller (LLC). It merges sporadic input-arrival pulses and a periodic deadline into event descriptors, and tags each one. Events are buffered in a small circular queue and released to the evaluation pipeline at most once every SLOT cycles. It sits between the monitor's input interface and the evaluation datapath, and drives the `llc_tag` and queue-status signals.

---
 rtl/llc_event_scheduler_if.sv | 30 +++
 rtl/llc_event_scheduler.sv | 145 ++++++++++++++
 tb/tb_llc_event_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/llc_event_scheduler_if.sv
// Handshake/status bundle between the LLC event scheduler and its neighbours.
// The master drives enable and arrival pulses. The slave (the scheduler) drives queue status and popped events.
interface llc_event_scheduler_if #(
    parameter int NUM_IN = 2,
    parameter int TAG_W  = 8
);
    logic              en;
    logic [NUM_IN-1:0] new_input;
    logic              q_push;
    logic              q_push_valid;
    logic              q_pop;
    logic              q_pop_valid;
    logic              ev_valid;
    logic [NUM_IN-1:0] ev_inputs;
    logic              ev_periodic;
    logic [TAG_W-1:0]  llc_tag;
    logic [7:0]        dropped;

    modport master (
        output en, new_input,
        input  q_push, q_push_valid, q_pop, q_pop_valid,
        input  ev_valid, ev_inputs, ev_periodic, llc_tag, dropped
    );

    modport slave (
        input  en, new_input,
        output q_push, q_push_valid, q_pop, q_pop_valid,
        output ev_valid, ev_inputs, ev_periodic, llc_tag, dropped
    );
endinterface

// File: rtl/llc_event_scheduler.sv
// RTLola LLC event scheduler: merges arrivals and a periodic deadline into tagged events, queues them,
// and releases one every SLOT cycles. Define SCHED_COALESCE_EN to OR-merge full-queue pushes into the tail entry.
module llc_event_scheduler #(
    parameter int NUM_IN = 2,
    parameter int PERIOD = 500,
    parameter int DEPTH  = 4,
    parameter int SLOT   = 4,
    parameter int TAG_W  = 8
) (
    input logic clk,
    input logic rst,
    llc_event_scheduler_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PCNT_W = $clog2(PERIOD);
    localparam int SLOT_W = $clog2(SLOT);

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t             state;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [PCNT_W-1:0]  dl_cnt;
    logic [TAG_W-1:0]   tag_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [NUM_IN:0]    mask_mem [DEPTH];
    logic [TAG_W-1:0]   tag_mem  [DEPTH];

    logic              deadline;
    logic [NUM_IN:0]   ev_bits;
    logic              full;
    logic              push_try;
    logic              push_ok;
    logic              pop_ok;
    logic              merge;
    logic              drop;
    logic [PTR_W-1:0]  tail_ptr;

    always_comb begin
        deadline = bus.en && (dl_cnt == PCNT_W'(PERIOD - 1));
        ev_bits  = {bus.new_input, deadline};
        full     = (count == CNT_W'(DEPTH));
        push_try = bus.en && (|ev_bits);
        push_ok  = push_try && !full;
        pop_ok   = bus.en && (state == IDLE) && (count != '0);
        tail_ptr = wr_ptr - PTR_W'(1);
`ifdef SCHED_COALESCE_EN
        merge    = push_try && full;
        drop     = 1'b0;
`else
        merge    = 1'b0;
        drop     = push_try && full;
`endif
    end

    // Queue storage is plain data; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mask_mem[wr_ptr] <= ev_bits;
            tag_mem[wr_ptr]  <= tag_cnt;
        end else if (merge) begin
            mask_mem[tail_ptr] <= mask_mem[tail_ptr] | ev_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            slot_cnt         <= '0;
            dl_cnt           <= '0;
            tag_cnt          <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.q_push       <= 1'b0;
            bus.q_push_valid <= 1'b0;
            bus.q_pop        <= 1'b0;
            bus.q_pop_valid  <= 1'b0;
            bus.ev_valid     <= 1'b0;
            bus.ev_inputs    <= '0;
            bus.ev_periodic  <= 1'b0;
            bus.llc_tag      <= '0;
            bus.dropped      <= '0;
        end else begin
            bus.q_push       <= push_try;
            bus.q_push_valid <= push_ok;
            bus.q_pop        <= bus.en && (state == IDLE);
            bus.q_pop_valid  <= pop_ok;
            bus.ev_valid     <= pop_ok;

            if (bus.en) begin
                if (dl_cnt == PCNT_W'(PERIOD - 1))
                    dl_cnt <= '0;
                else
                    dl_cnt <= dl_cnt + PCNT_W'(1);
            end

            if (push_ok) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                tag_cnt <= tag_cnt + TAG_W'(1);
            end

            if (pop_ok) begin
                bus.ev_inputs   <= mask_mem[rd_ptr][NUM_IN:1];
                bus.ev_periodic <= mask_mem[rd_ptr][0];
                bus.llc_tag     <= tag_mem[rd_ptr];
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end

            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase

            if (drop)
                bus.dropped <= sat_inc(bus.dropped);

            // WAIT lasts SLOT-1 cycles, so consecutive pops land exactly SLOT cycles apart.
            case (state)
                IDLE: begin
                    if (pop_ok) begin
                        state    <= WAIT;
                        slot_cnt <= SLOT_W'(SLOT - 2);
                    end
                end
                WAIT: begin
                    if (bus.en) begin
                        if (slot_cnt == '0)
                            state <= IDLE;
                        else
                            slot_cnt <= slot_cnt - SLOT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_llc_event_scheduler.sv
// Directed testbench for llc_event_scheduler (default parameters).
// Cycle numbers count from the first cycle after reset release.
module tb_llc_event_scheduler;
    logic clk;
    logic rst;
    int   chk;
    int   pass;
    int   cur;

    llc_event_scheduler_if #(.NUM_IN(2), .TAG_W(8)) bus ();

    llc_event_scheduler #(
        .NUM_IN(2), .PERIOD(500), .DEPTH(4), .SLOT(4), .TAG_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.new_input = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        cur = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.new_input = 2'b11;
        tick();
        tick();
        chk++; if ({bus.q_push, bus.q_push_valid, bus.q_pop, bus.q_pop_valid, bus.ev_valid, bus.ev_periodic} !== 6'b0)
            $display("FAIL reset_strobes got %b want 000000", {bus.q_push, bus.q_push_valid, bus.q_pop, bus.q_pop_valid, bus.ev_valid, bus.ev_periodic});
        else pass++;
        chk++; if ({bus.ev_inputs, bus.llc_tag, bus.dropped} !== 18'b0)
            $display("FAIL reset_data got inputs=%b tag=%0d dropped=%0d want 0", bus.ev_inputs, bus.llc_tag, bus.dropped);
        else pass++;
        rst = 1'b0;
        bus.new_input = 2'b00;
        cur = 0;
    endtask

    task automatic test_first_deadline();
        int first_push;
        int first_ev;
        logic [1:0] ins;
        logic per;
        logic [7:0] tg;
        do_reset();
        first_push = -1;
        first_ev = -1;
        ins = 2'bxx; per = 1'bx; tg = 'x;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (first_push < 0 && bus.q_push === 1'b1) first_push = cur;
            if (first_ev < 0 && bus.ev_valid === 1'b1) begin
                first_ev = cur; ins = bus.ev_inputs; per = bus.ev_periodic; tg = bus.llc_tag;
            end
        end
        chk++; if (first_push !== 500) $display("FAIL deadline_push_cycle got %0d want 500", first_push); else pass++;
        chk++; if (first_ev !== 501) $display("FAIL deadline_ev_cycle got %0d want 501", first_ev); else pass++;
        chk++; if ({ins, per, tg} !== {2'b00, 1'b1, 8'd0})
            $display("FAIL deadline_event got inputs=%b periodic=%b tag=%0d want 00/1/0", ins, per, tg);
        else pass++;
    endtask

    task automatic test_single();
        do_reset();
        while (cur < 100) tick();
        bus.new_input = 2'b01;
        tick();
        bus.new_input = 2'b00;
        chk++; if ({bus.q_push, bus.q_push_valid, bus.ev_valid} !== 3'b110)
            $display("FAIL single_push got push=%b valid=%b ev=%b want 1 1 0", bus.q_push, bus.q_push_valid, bus.ev_valid);
        else pass++;
        chk++; if (bus.q_pop !== 1'b1) $display("FAIL single_q_pop_idle got %b want 1", bus.q_pop); else pass++;
        tick();
        chk++; if ({bus.ev_valid, bus.q_pop_valid, bus.ev_inputs, bus.ev_periodic, bus.llc_tag} !== {1'b1, 1'b1, 2'b01, 1'b0, 8'd0})
            $display("FAIL single_event got ev=%b popv=%b inputs=%b periodic=%b tag=%0d want 1 1 01 0 0",
                     bus.ev_valid, bus.q_pop_valid, bus.ev_inputs, bus.ev_periodic, bus.llc_tag);
        else pass++;
        tick();
        chk++; if ({bus.ev_valid, bus.ev_inputs, bus.q_pop} !== {1'b0, 2'b01, 1'b0})
            $display("FAIL single_hold got ev=%b inputs=%b q_pop=%b want 0 01 0", bus.ev_valid, bus.ev_inputs, bus.q_pop);
        else pass++;
    endtask

    task automatic test_coincidence();
        int evs;
        do_reset();
        while (cur < 499) tick();
        bus.new_input = 2'b11;
        tick();
        bus.new_input = 2'b00;
        tick();
        chk++; if ({bus.ev_valid, bus.ev_inputs, bus.ev_periodic, bus.llc_tag} !== {1'b1, 2'b11, 1'b1, 8'd0})
            $display("FAIL coincide_event got ev=%b inputs=%b periodic=%b tag=%0d want 1 11 1 0",
                     bus.ev_valid, bus.ev_inputs, bus.ev_periodic, bus.llc_tag);
        else pass++;
        evs = 0;
        while (cur < 505) begin
            tick();
            if (bus.ev_valid === 1'b1) evs++;
        end
        chk++; if (evs !== 0) $display("FAIL coincide_single_event got %0d extra events want 0", evs); else pass++;
        bus.new_input = 2'b10;
        tick();
        bus.new_input = 2'b00;
        tick();
        chk++; if ({bus.ev_valid, bus.ev_inputs, bus.llc_tag} !== {1'b1, 2'b10, 8'd1})
            $display("FAIL coincide_next_tag got ev=%b inputs=%b tag=%0d want 1 10 1", bus.ev_valid, bus.ev_inputs, bus.llc_tag);
        else pass++;
    endtask

    task automatic test_burst();
        int ev_cyc [$];
        int ev_tag [$];
        logic [26:0] pv;
        logic [26:0] pv_exp;
        logic [7:0] drop_exp;
        int ecyc [6];
        do_reset();
        while (cur < 10) tick();
        pv = '0;
        for (int r = 0; r < 26; r++) begin
            bus.new_input = (r < 8) ? 2'b01 : 2'b00;
            tick();
            pv[r + 1] = bus.q_push_valid;
            if (bus.ev_valid === 1'b1) begin
                ev_cyc.push_back(r + 1);
                ev_tag.push_back(int'(bus.llc_tag));
            end
        end
        bus.new_input = 2'b00;
        pv_exp = '0;
        pv_exp[1] = 1'b1; pv_exp[2] = 1'b1; pv_exp[3] = 1'b1;
        pv_exp[4] = 1'b1; pv_exp[5] = 1'b1; pv_exp[7] = 1'b1;
        chk++; if (pv !== pv_exp) $display("FAIL burst_push_valid got %b want %b", pv, pv_exp); else pass++;
        chk++; if (ev_cyc.size() !== 6) $display("FAIL burst_event_count got %0d want 6", ev_cyc.size()); else pass++;
        ecyc = '{2, 6, 10, 14, 18, 22};
        for (int k = 0; k < 6; k++) begin
            if (k < ev_cyc.size()) begin
                chk++; if (ev_cyc[k] !== ecyc[k] || ev_tag[k] !== k)
                    $display("FAIL burst_event%0d got cycle=%0d tag=%0d want cycle=%0d tag=%0d", k, ev_cyc[k], ev_tag[k], ecyc[k], k);
                else pass++;
            end
        end
`ifdef SCHED_COALESCE_EN
        drop_exp = 8'd0;
`else
        drop_exp = 8'd2;
`endif
        chk++; if (bus.dropped !== drop_exp) $display("FAIL burst_dropped got %0d want %0d", bus.dropped, drop_exp); else pass++;
    endtask

    task automatic test_reset_mid();
        int evs;
        bus.new_input = 2'b01;
        tick();
        bus.new_input = 2'b00;
        rst = 1'b1;
        tick();
        chk++; if ({bus.ev_valid, bus.q_push, bus.dropped} !== 10'b0)
            $display("FAIL midreset_clear got ev=%b push=%b dropped=%0d want 0 0 0", bus.ev_valid, bus.q_push, bus.dropped);
        else pass++;
        rst = 1'b0;
        cur = 0;
        evs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ev_valid === 1'b1) evs++;
        end
        chk++; if (evs !== 0) $display("FAIL midreset_discard got %0d events want 0", evs); else pass++;
    endtask

    task automatic test_tag_wrap();
        int n;
        int bad;
        int per_cnt;
        int tag256;
        int tag257;
        do_reset();
        n = 0; bad = 0; per_cnt = 0; tag256 = -1; tag257 = -1;
        while (cur < 1040) begin
            bus.new_input = ((cur % 4) == 3 && cur <= 1027) ? 2'b01 : 2'b00;
            tick();
            if (bus.ev_valid === 1'b1) begin
                if (int'(bus.llc_tag) !== (n % 256)) bad++;
                if (bus.ev_periodic === 1'b1) per_cnt++;
                if (n == 255) tag256 = int'(bus.llc_tag);
                if (n == 256) tag257 = int'(bus.llc_tag);
                n++;
            end
        end
        bus.new_input = 2'b00;
        chk++; if (n !== 257) $display("FAIL wrap_event_count got %0d want 257", n); else pass++;
        chk++; if (bad !== 0) $display("FAIL wrap_tag_sequence got %0d out-of-order tags want 0", bad); else pass++;
        chk++; if (tag256 !== 255) $display("FAIL wrap_tag256 got %0d want 255", tag256); else pass++;
        chk++; if (tag257 !== 0) $display("FAIL wrap_tag257 got %0d want 0", tag257); else pass++;
        chk++; if (per_cnt !== 2) $display("FAIL wrap_periodic_merged got %0d want 2", per_cnt); else pass++;
        chk++; if (bus.dropped !== 8'd0) $display("FAIL wrap_dropped got %0d want 0", bus.dropped); else pass++;
    endtask

    task automatic test_enable_hold();
        int bad;
        int ev_at;
        int push_at;
        logic per;
        logic [7:0] tg;
        do_reset();
        bus.new_input = 2'b01;
        tick();
        tick();
        chk++; if ({bus.ev_valid, bus.llc_tag} !== {1'b1, 8'd0})
            $display("FAIL hold_first_pop got ev=%b tag=%0d want 1 0", bus.ev_valid, bus.llc_tag);
        else pass++;
        bus.en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.new_input = (i % 2 == 0) ? 2'b11 : 2'b00;
            tick();
            if ({bus.q_push, bus.q_push_valid, bus.ev_valid, bus.q_pop} !== 4'b0) bad++;
        end
        chk++; if (bad !== 0) $display("FAIL hold_no_strobes got %0d active cycles want 0", bad); else pass++;
        bus.en = 1'b1;
        bus.new_input = 2'b00;
        ev_at = -1; push_at = -1; per = 1'bx; tg = 'x;
        while (cur < 520) begin
            tick();
            if (ev_at < 0 && bus.ev_valid === 1'b1) begin
                ev_at = cur;
                chk++; if (bus.llc_tag !== 8'd1) $display("FAIL hold_second_tag got %0d want 1", bus.llc_tag); else pass++;
            end
            if (push_at < 0 && cur > 12 && bus.q_push === 1'b1) push_at = cur;
            if (cur == 511) begin per = bus.ev_periodic; tg = bus.llc_tag; end
        end
        chk++; if (ev_at !== 16) $display("FAIL hold_pop_delay got cycle %0d want 16", ev_at); else pass++;
        chk++; if (push_at !== 510) $display("FAIL hold_deadline_frozen got push cycle %0d want 510", push_at); else pass++;
        chk++; if ({per, tg} !== {1'b1, 8'd2}) $display("FAIL hold_deadline_event got periodic=%b tag=%0d want 1 2", per, tg); else pass++;
        chk++; if (bus.dropped !== 8'd0) $display("FAIL hold_dropped got %0d want 0", bus.dropped); else pass++;
    endtask

    initial begin
        chk = 0;
        pass = 0;
        cur = 0;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.new_input = 2'b00;
        test_reset();
        test_first_deadline();
        test_single();
        test_coincidence();
        test_burst();
        test_reset_mid();
        test_tag_wrap();
        test_enable_hold();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit got running want finished");
        $fatal(1, "timeout");
    end
endmodule
